// File: rtl/linha_prefetch_pkg.sv
// Shared definitions for the tile-row prefetcher.
//   - default screen geometry and the derived tile/row counts
//   - colour, row-tag and coordinate types
//   - fetch FSM state encoding
//   - next_row(): row successor with wrap at the bottom of the frame
package linha_prefetch_pkg;

  localparam int DEF_SCREEN_WIDTH  = 640;
  localparam int DEF_SCREEN_HEIGHT = 480;
  localparam int DEF_BLOCK_BITS    = 4;

  localparam int TILES = DEF_SCREEN_WIDTH  >> DEF_BLOCK_BITS;  // 40
  localparam int ROWS  = DEF_SCREEN_HEIGHT >> DEF_BLOCK_BITS;  // 30

  localparam int ROW_W = 5;

  typedef logic [5:0]       color_t;   // {R[1:0], G[1:0], B[1:0]}
  typedef logic [ROW_W-1:0] row_t;
  typedef logic [9:0]       coord_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } fetch_state_t;

  function automatic row_t next_row(input row_t row, input int rows);
    if (int'(row) >= rows - 1) return '0;
    return row + row_t'(1);
  endfunction

endpackage

// File: rtl/linha_prefetch_if.sv
// Tile-map read bus.
//   mapa_x / mapa_y : tile column / row requested
//   mapa_read       : request, held until mapa_valid
//   mapa_valid      : response strobe, mapa_R/G/B valid in this cycle
//   mapa_R/G/B      : tile colour
// master = prefetcher side, slave = map side.
interface linha_prefetch_if;
  import linha_prefetch_pkg::*;

  coord_t     mapa_x;
  coord_t     mapa_y;
  logic       mapa_read;
  logic       mapa_valid;
  logic [1:0] mapa_R;
  logic [1:0] mapa_G;
  logic [1:0] mapa_B;

  modport master (
    output mapa_x, mapa_y, mapa_read,
    input  mapa_valid, mapa_R, mapa_G, mapa_B
  );

  modport slave (
    input  mapa_x, mapa_y, mapa_read,
    output mapa_valid, mapa_R, mapa_G, mapa_B
  );
endinterface

// File: rtl/linha_buffer.sv
// Two-bank line buffer holding one tile row per bank.
//   i_we / i_wr_bank / i_wr_idx / i_wr_data : fetch write port
//   i_rd_en / i_rd_bank / i_rd_idx          : pixel read request
//   o_rd_data                               : registered read data, zero
//                                             in the cycle after no read
module linha_buffer
  import linha_prefetch_pkg::*;
#(
  parameter int DEPTH = TILES,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic             i_wr_bank,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  color_t           i_wr_data,
  input  logic             i_rd_en,
  input  logic             i_rd_bank,
  input  logic [IDX_W-1:0] i_rd_idx,
  output color_t           o_rd_data
);

  color_t r_bank0 [DEPTH];
  color_t r_bank1 [DEPTH];
  color_t r_rd_data;

  // NOTE: storage arrays carry no reset; the per-bank valid bits in the
  // parent make stale contents unobservable, and a reset here would stop
  // the arrays mapping onto RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      if (i_wr_bank) r_bank1[i_wr_idx] <= i_wr_data;
      else           r_bank0[i_wr_idx] <= i_wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= i_rd_bank ? r_bank1[i_rd_idx] : r_bank0[i_rd_idx];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/linha_prefetch.sv
// Tile-row prefetcher for a tile-mapped display.
// Keeps the tile row of the line being shown in the front bank while the
// next row is fetched from the tile map into the back bank.
//   clk, rst_n          : clock, asynchronous active-low reset
//   line_start, next_y  : hblank pulse and the upcoming visible line
//   pixel_read, pixel_x : renderer colour lookup (one-cycle latency)
//   R, G, B             : registered tile colour
//   mapa                : tile-map read bus (master side)
//   busy                : fetch in progress
//   underrun            : sticky, a line began without its row buffered
module linha_prefetch
  import linha_prefetch_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int BLOCK_BITS    = DEF_BLOCK_BITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    line_start,
  input  coord_t                  next_y,
  input  logic                    pixel_read,
  input  coord_t                  pixel_x,
  output logic [1:0]              R,
  output logic [1:0]              G,
  output logic [1:0]              B,
  linha_prefetch_if.master        mapa,
  output logic                    busy,
  output logic                    underrun
);

  localparam int BLOCK_SIZE = 1 << BLOCK_BITS;
  localparam int N_TILES    = SCREEN_WIDTH / BLOCK_SIZE;
  localparam int N_ROWS     = SCREEN_HEIGHT / BLOCK_SIZE;
  localparam int IDX_W      = $clog2(N_TILES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TILES - 1);
  localparam coord_t X_LIMIT = coord_t'(SCREEN_WIDTH);

  fetch_state_t     r_state;
  logic [IDX_W-1:0] r_idx;
  row_t             r_target;
  logic             r_front;
  logic [1:0]       r_valid;
  row_t             r_tag [2];
  logic             r_underrun;
  logic             r_mapa_read;
  coord_t           r_mapa_x;
  coord_t           r_mapa_y;

  row_t   w_row;
  row_t   w_next_row;
  row_t   w_fetch_row;
  logic   w_back;
  logic   w_new_back;
  logic   w_front_hit;
  logic   w_back_hit;
  logic   w_back_has_next;
  logic   w_accept;
  logic   w_start;
  logic   w_swap;
  logic   w_underrun;
  logic   w_rd_en;
  color_t w_rd_data;

  assign w_row           = row_t'(next_y >> BLOCK_BITS);
  assign w_next_row      = next_row(w_row, N_ROWS);
  assign w_back          = ~r_front;
  assign w_front_hit     = r_valid[r_front] && (r_tag[r_front] == w_row);
  assign w_back_hit      = r_valid[w_back]  && (r_tag[w_back]  == w_row);
  assign w_back_has_next = r_valid[w_back]  && (r_tag[w_back]  == w_next_row);
  assign w_accept        = (r_state != ST_IDLE) && mapa.mapa_valid;
  // A swap turns the current front into the bank that gets refilled.
  assign w_new_back      = w_swap ? r_front : w_back;

  // Line-start policy: decide swap / fetch start / underrun.
  // NOTE: every always_comb output gets a default first so no path can
  // infer a latch.
  always_comb begin
    w_start     = 1'b0;
    w_swap      = 1'b0;
    w_underrun  = 1'b0;
    w_fetch_row = w_next_row;
    if (line_start) begin
      if (w_front_hit) begin
        if (!w_back_has_next && (r_state == ST_IDLE)) w_start = 1'b1;
      end else if (w_back_hit) begin
        w_swap  = 1'b1;
        w_start = 1'b1;
      end else begin
        w_underrun = 1'b1;
        // A fetch already chasing the needed row is left alone rather than
        // restarted every line of that row.
        if (!((r_state != ST_IDLE) && (r_target == w_row))) begin
          w_start     = 1'b1;
          w_fetch_row = w_row;
        end
      end
    end
  end

  // Fetch FSM and bank bookkeeping. A fetch start takes priority over a
  // response in the same cycle: that response belongs to the aborted fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_target    <= '0;
      r_front     <= 1'b0;
      r_valid     <= '0;
      r_tag[0]    <= '0;
      r_tag[1]    <= '0;
      r_underrun  <= 1'b0;
      r_mapa_read <= 1'b0;
      r_mapa_x    <= '0;
      r_mapa_y    <= '0;
    end else begin
      if (w_underrun) r_underrun <= 1'b1;
      if (w_swap)     r_front    <= ~r_front;

      if (w_start) begin
        r_state              <= ST_REQ;
        r_idx                <= '0;
        r_target             <= w_fetch_row;
        r_valid[w_new_back]  <= 1'b0;
        r_mapa_read          <= 1'b1;
        r_mapa_x             <= '0;
        r_mapa_y             <= coord_t'(w_fetch_row);
      end else if (w_accept) begin
        if (r_idx == LAST_IDX) begin
          r_state         <= ST_IDLE;
          r_mapa_read     <= 1'b0;
          r_valid[w_back] <= 1'b1;
          r_tag[w_back]   <= r_target;
        end else begin
          r_state  <= ST_REQ;
          r_idx    <= r_idx + IDX_W'(1);
          r_mapa_x <= coord_t'(r_idx + IDX_W'(1));
        end
      end else if (r_state == ST_REQ) begin
        r_state <= ST_WAIT;
      end
    end
  end

  // Pixel lookups always see the pre-swap front bank.
  assign w_rd_en = pixel_read && (pixel_x < X_LIMIT) && r_valid[r_front];

  linha_buffer #(
    .DEPTH (N_TILES),
    .IDX_W (IDX_W)
  ) u_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_accept && !w_start),
    .i_wr_bank (w_back),
    .i_wr_idx  (r_idx),
    .i_wr_data ({mapa.mapa_R, mapa.mapa_G, mapa.mapa_B}),
    .i_rd_en   (w_rd_en),
    .i_rd_bank (r_front),
    .i_rd_idx  (IDX_W'(pixel_x >> BLOCK_BITS)),
    .o_rd_data (w_rd_data)
  );

  assign R = w_rd_data[5:4];
  assign G = w_rd_data[3:2];
  assign B = w_rd_data[1:0];

  assign mapa.mapa_x    = r_mapa_x;
  assign mapa.mapa_y    = r_mapa_y;
  assign mapa.mapa_read = r_mapa_read;
  // The request is held for the whole fetch, so it doubles as busy.
  assign busy           = r_mapa_read;
  assign underrun       = r_underrun;

endmodule

// File: tb/tb_linha_prefetch.sv
module tb_linha_prefetch;
  import linha_prefetch_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line_start = 1'b0;
  coord_t     next_y = '0;
  logic       pixel_read = 1'b0;
  coord_t     pixel_x = '0;
  logic [1:0] R, G, B;
  logic       busy, underrun;

  linha_prefetch_if mapa_bus ();

  // Map model: colour = mapa_x[5:0], response after map_delay wait cycles.
  logic [3:0] map_delay = 4'd0;
  logic       map_en = 1'b1;
  logic       stray_valid = 1'b0;
  logic [3:0] wait_cnt;

  assign mapa_bus.mapa_valid = (mapa_bus.mapa_read && map_en && (wait_cnt >= map_delay))
                               || stray_valid;
  assign mapa_bus.mapa_R = mapa_bus.mapa_x[5:4];
  assign mapa_bus.mapa_G = mapa_bus.mapa_x[3:2];
  assign mapa_bus.mapa_B = mapa_bus.mapa_x[1:0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= '0;
    else if (!mapa_bus.mapa_read || mapa_bus.mapa_valid) wait_cnt <= '0;
    else wait_cnt <= wait_cnt + 4'd1;
  end

  linha_prefetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_start (line_start),
    .next_y     (next_y),
    .pixel_read (pixel_read),
    .pixel_x    (pixel_x),
    .R          (R),
    .G          (G),
    .B          (B),
    .mapa       (mapa_bus),
    .busy       (busy),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues: {mapa_x, mapa_y} per map handshake, colour per probe.
  logic [19:0] exp_req[$];
  logic [5:0]  exp_pix[$];
  logic        probe = 1'b0;

  // Monitor: samples on the falling edge, away from the active edge.
  logic   pend = 1'b0;
  logic   prev_read = 1'b0, prev_hs = 1'b0, prev_ls = 1'b0;
  coord_t prev_x = '0, prev_y = '0;

  always @(negedge clk) begin
    if (pend) begin
      if (exp_pix.size() == 0) check("pixel_unexpected", 1, 0);
      else check("pixel_rgb", {26'd0, R, G, B}, {26'd0, exp_pix.pop_front()});
    end
    if (mapa_bus.mapa_read && mapa_bus.mapa_valid) begin
      if (exp_req.size() == 0) check("map_req_unexpected", 1, 0);
      else check("map_req_xy", {12'd0, mapa_bus.mapa_x, mapa_bus.mapa_y},
                 {12'd0, exp_req.pop_front()});
    end
    if (prev_read && !prev_hs && !prev_ls && mapa_bus.mapa_read)
      check("map_req_stable", {12'd0, mapa_bus.mapa_x, mapa_bus.mapa_y},
            {12'd0, prev_x, prev_y});
    pend      <= probe;
    prev_read <= mapa_bus.mapa_read;
    prev_hs   <= mapa_bus.mapa_read && mapa_bus.mapa_valid;
    prev_ls   <= line_start;
    prev_x    <= mapa_bus.mapa_x;
    prev_y    <= mapa_bus.mapa_y;
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input int y);
    for (int i = 0; i < 40; i++) exp_req.push_back({10'(i), 10'(y)});
  endtask

  task automatic pulse_line(input int y);
    line_start = 1'b1;
    next_y     = 10'(y);
    step();
    line_start = 1'b0;
  endtask

  task automatic probe_px(input logic rd, input int x, input logic [5:0] exp);
    pixel_read = rd;
    pixel_x    = 10'(x);
    probe      = 1'b1;
    exp_pix.push_back(exp);
    step();
    pixel_read = 1'b0;
    probe      = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && busy; i++) step();
    check(name, {31'd0, busy}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_mapa_read", {31'd0, mapa_bus.mapa_read}, 0);
    check("rst_busy",      {31'd0, busy}, 0);
    check("rst_underrun",  {31'd0, underrun}, 0);
    check("rst_rgb",       {26'd0, R, G, B}, 0);
    check("rst_mapa_x",    {22'd0, mapa_bus.mapa_x}, 0);
    rst_n = 1'b1;
    step();

    // Cold start: row 0 missing -> underrun, fetch row 0 into back bank
    push_row(0);
    pulse_line(0);
    check("cold_underrun", {31'd0, underrun}, 1);
    check("cold_busy",     {31'd0, busy}, 1);
    wait_idle("cold_fetch_done", 100);
    check("cold_queue_drained", exp_req.size(), 0);

    // Swap on line 1; same-cycle pixel sees the pre-swap (invalid) front
    push_row(1);
    line_start = 1'b1;
    next_y     = 10'd1;
    probe_px(1'b1, 35, 6'd0);
    line_start = 1'b0;
    probe_px(1'b1, 35,  6'd2);
    probe_px(1'b1, 300, 6'd18);
    probe_px(1'b1, 639, 6'd39);
    probe_px(1'b1, 640, 6'd0);
    probe_px(1'b0, 35,  6'd0);
    wait_idle("row1_fetch_done", 100);

    // Slow map: three wait cycles per request, request held stable
    map_delay = 4'd3;
    push_row(2);
    pulse_line(16);
    check("slow_busy", {31'd0, busy}, 1);
    wait_idle("slow_fetch_done", 400);
    check("slow_queue_drained", exp_req.size(), 0);
    probe_px(1'b1, 100, 6'd6);
    map_delay = 4'd0;

    // Front hit with next row already buffered: nothing to fetch
    pulse_line(17);
    check("hit_no_fetch", {31'd0, busy}, 0);

    // Rows 28, 29, then wrap to row 0
    push_row(28);
    pulse_line(448);
    wait_idle("row28_done", 100);
    push_row(29);
    pulse_line(448);
    wait_idle("row29_done", 100);
    push_row(0);
    pulse_line(464);
    check("wrap_mapa_y", {22'd0, mapa_bus.mapa_y}, 0);
    wait_idle("wrap_done", 100);
    check("wrap_underrun_sticky", {31'd0, underrun}, 1);

    // Reset while waiting on the map drops the request at once
    map_en = 1'b0;
    push_row(1);
    pulse_line(0);
    step();
    step();
    check("wait_busy",     {31'd0, busy}, 1);
    check("wait_mapa_x",   {22'd0, mapa_bus.mapa_x}, 0);
    rst_n = 1'b0;
    #1;
    check("async_drop_read", {31'd0, mapa_bus.mapa_read}, 0);
    check("async_busy",      {31'd0, busy}, 0);
    check("async_underrun",  {31'd0, underrun}, 0);
    exp_req.delete();
    step();
    rst_n  = 1'b1;
    map_en = 1'b1;
    step();
    stray_valid = 1'b1;
    step();
    stray_valid = 1'b0;
    step();
    check("stray_valid_ignored", {31'd0, busy}, 0);
    probe_px(1'b1, 35, 6'd0);

    // Abort mid-fetch: row 0 in flight, line for row 10 arrives
    push_row(0);
    pulse_line(0);
    repeat (5) step();
    map_en = 1'b0;
    step();
    step();
    exp_req.delete();
    push_row(10);
    pulse_line(160);
    check("abort_mapa_x",   {22'd0, mapa_bus.mapa_x}, 0);
    check("abort_mapa_y",   {22'd0, mapa_bus.mapa_y}, 10);
    check("abort_underrun", {31'd0, underrun}, 1);
    map_en = 1'b1;
    wait_idle("abort_fetch_done", 100);
    push_row(11);
    pulse_line(160);
    probe_px(1'b1, 639, 6'd39);
    wait_idle("row11_done", 100);

    step();
    step();
    check("final_req_queue", exp_req.size(), 0);
    check("final_pix_queue", exp_pix.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
